// File: rtl/div_if.sv
// Divider request/result bundle shared by the issuing stage and the divider.
// The issuing stage drives the request side and the divider drives the result side.
interface div_if #(
    parameter int WIDTH = 16
);
    logic             div_en;
    logic [WIDTH-1:0] div_op1;
    logic [WIDTH-1:0] div_op2;
    logic [WIDTH-1:0] div_out;
    logic [WIDTH-1:0] div_rem;
    logic             div_valid_wb;
    logic             div_dbz;
    logic             div_busy;

    // Issuing side: sends a request and reads the results.
    modport master (
        output div_en, div_op1, div_op2,
        input  div_out, div_rem, div_valid_wb, div_dbz, div_busy
    );

    // Divider side: accepts a request and returns the results.
    modport slave (
        input  div_en, div_op1, div_op2,
        output div_out, div_rem, div_valid_wb, div_dbz, div_busy
    );
endinterface

// File: rtl/divider.sv
// Multi-cycle radix-2 restoring divider, signed or unsigned.
// Each operation takes one quotient bit per cycle, then one cycle for sign fix-up.
// The result is ready 17 cycles after the request is accepted.
// Requests use the en / valid_wb handshake, the same one the Booth multiplier uses.
module divider #(
    parameter int WIDTH  = 16,
    parameter bit SIGNED = 1'b1
) (
    input logic  clk,
    input logic  rst_n,
    div_if.slave bus
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t           state;
    logic [CW-1:0]    counter;
    logic [WIDTH-1:0] quo;       // partial quotient; holds the dividend magnitude at start
    logic [WIDTH-1:0] rem;       // partial remainder
    logic [WIDTH:0]   dvsr;      // divisor magnitude; one extra bit so |-2^(W-1)| is exact
    logic             sign_q;
    logic             sign_r;
    logic             dbz;

    logic [WIDTH-1:0] out_q;
    logic [WIDTH-1:0] rem_q;
    logic             valid_q;
    logic             dbz_q;
    logic             busy_q;

    // Operand signs and magnitudes, taken from the request as it is accepted.
    logic             s1;
    logic             s2;
    logic [WIDTH-1:0] mag1;
    logic [WIDTH:0]   mag2;

    assign s1   = SIGNED & bus.div_op1[WIDTH-1];
    assign s2   = SIGNED & bus.div_op2[WIDTH-1];
    assign mag1 = s1 ? (WIDTH'(0) - bus.div_op1) : bus.div_op1;
    assign mag2 = s2 ? ((WIDTH+1)'(0) - {1'b1, bus.div_op2}) : {1'b0, bus.div_op2};

    // One restoring step: shift {rem,quo} left, then try subtracting the divisor.
    // The true difference always fits in WIDTH+1 signed bits, so the top bit of
    // the result reliably says "negative, restore".
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH:0]   trial;
    logic             restore;
    logic [WIDTH-1:0] rem_nxt;
    logic [WIDTH-1:0] quo_nxt;

    assign rem_sh  = {rem, quo[WIDTH-1]};
    assign trial   = rem_sh - dvsr;
    assign restore = trial[WIDTH];
    assign rem_nxt = restore ? rem_sh[WIDTH-1:0] : trial[WIDTH-1:0];
    assign quo_nxt = {quo[WIDTH-2:0], ~restore};

    // Control FSM and datapath: accept in IDLE, iterate in RUN, sign-correct in FIX.
    // NOTE: every register here is assigned with <= so all of them update together
    // from values sampled before the edge; a blocking '=' would let later lines see
    // values already updated in this same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            counter <= '0;
            quo     <= '0;
            rem     <= '0;
            dvsr    <= '0;
            sign_q  <= 1'b0;
            sign_r  <= 1'b0;
            dbz     <= 1'b0;
            out_q   <= '0;
            rem_q   <= '0;
            valid_q <= 1'b0;
            dbz_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            dbz_q   <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.div_en) begin
                        quo     <= mag1;
                        dvsr    <= mag2;
                        sign_q  <= s1 ^ s2;
                        sign_r  <= s1;
                        dbz     <= (bus.div_op2 == '0);
                        rem     <= '0;
                        counter <= '0;
                        busy_q  <= 1'b1;
                        state   <= RUN;
                    end
                end
                RUN: begin
                    rem     <= rem_nxt;
                    quo     <= quo_nxt;
                    counter <= counter + 1'b1;
                    if (counter == CW'(WIDTH - 1)) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    // With a zero divisor the iteration leaves |op1| in rem,
                    // so the remainder path gives op1 back unchanged.
                    out_q   <= dbz ? '1 : (sign_q ? (WIDTH'(0) - quo) : quo);
                    rem_q   <= sign_r ? (WIDTH'(0) - rem) : rem;
                    valid_q <= 1'b1;
                    dbz_q   <= dbz;
                    busy_q  <= 1'b0;
                    state   <= IDLE;
                end
                default: begin
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

    assign bus.div_out      = out_q;
    assign bus.div_rem      = rem_q;
    assign bus.div_valid_wb = valid_q;
    assign bus.div_dbz      = dbz_q;
    assign bus.div_busy     = busy_q;
endmodule

// File: tb/tb_divider.sv
// Directed self-checking bench for the divider. It drives a signed instance and an unsigned instance.
module tb_divider;
    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    div_if #(.WIDTH(16)) bs ();
    div_if #(.WIDTH(16)) bu ();

    divider #(.WIDTH(16), .SIGNED(1'b1)) dut_s (.clk(clk), .rst_n(rst_n), .bus(bs));
    divider #(.WIDTH(16), .SIGNED(1'b0)) dut_u (.clk(clk), .rst_n(rst_n), .bus(bu));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic vld(input bit uns);
        return uns ? bu.div_valid_wb : bs.div_valid_wb;
    endfunction

    function automatic logic [15:0] res_out(input bit uns);
        return uns ? bu.div_out : bs.div_out;
    endfunction

    function automatic logic [15:0] res_rem(input bit uns);
        return uns ? bu.div_rem : bs.div_rem;
    endfunction

    function automatic logic res_dbz(input bit uns);
        return uns ? bu.div_dbz : bs.div_dbz;
    endfunction

    function automatic logic res_busy(input bit uns);
        return uns ? bu.div_busy : bs.div_busy;
    endfunction

    task automatic drive(input bit uns, input logic en, input logic [15:0] a, input logic [15:0] b);
        if (uns) begin
            bu.div_en = en; bu.div_op1 = a; bu.div_op2 = b;
        end else begin
            bs.div_en = en; bs.div_op1 = a; bs.div_op2 = b;
        end
    endtask

    // Counts edges until the valid pulse appears. The count is bounded at 40 edges, and running out shows up as a latency error.
    task automatic wait_valid(input bit uns, output int n);
        n = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            n++;
            if (vld(uns)) break;
        end
    endtask

    task automatic do_op(input bit uns, input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] eq, input logic [15:0] er, input logic ed,
                         input string tag);
        int n;
        @(negedge clk);
        drive(uns, 1'b1, a, b);
        @(posedge clk);
        #1;
        // Scramble the operands after acceptance; the result must not change.
        drive(uns, 1'b0, ~a, b + 16'd3);
        check({tag, "_busy"}, 32'(res_busy(uns)), 32'd1);
        wait_valid(uns, n);
        check({tag, "_lat"}, 32'(n), 32'd17);
        check({tag, "_out"}, 32'(res_out(uns)), 32'(eq));
        check({tag, "_rem"}, 32'(res_rem(uns)), 32'(er));
        check({tag, "_dbz"}, 32'(res_dbz(uns)), 32'(ed));
        @(posedge clk);
        #1;
        check({tag, "_pulse"}, {30'd0, vld(uns), res_dbz(uns)}, 32'd0);
        check({tag, "_hold"}, 32'(res_out(uns)), 32'(eq));
    endtask

    initial begin
        int n;
        int extra;
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        drive(1'b0, 1'b0, 16'd0, 16'd0);
        drive(1'b1, 1'b0, 16'd0, 16'd0);
        #1;
        check("rst_out",   32'(bs.div_out), 32'd0);
        check("rst_rem",   32'(bs.div_rem), 32'd0);
        check("rst_flags", {29'd0, bs.div_valid_wb, bs.div_dbz, bs.div_busy}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Signed vectors: 100/7 = 14 r 2, and the sign combinations of it.
        do_op(1'b0, 16'd100,   16'd7,      16'd14,    16'd2,    1'b0, "pos_pos");
        do_op(1'b0, 16'hFF9C,  16'd7,      16'hFFF2,  16'hFFFE, 1'b0, "neg_pos");
        do_op(1'b0, 16'd100,   16'hFFF9,   16'hFFF2,  16'd2,    1'b0, "pos_neg");
        do_op(1'b0, 16'hFF9C,  16'hFFF9,   16'd14,    16'hFFFE, 1'b0, "neg_neg");
        do_op(1'b0, 16'h8000,  16'hFFFF,   16'h8000,  16'd0,    1'b0, "ovf");
        do_op(1'b0, 16'h8000,  16'd2,      16'hC000,  16'd0,    1'b0, "min_by2");
        do_op(1'b0, 16'd1234,  16'd0,      16'hFFFF,  16'd1234, 1'b1, "dbz_pos");
        do_op(1'b0, 16'hFFFB,  16'd0,      16'hFFFF,  16'hFFFB, 1'b1, "dbz_neg");

        // Back-to-back: div_en stays high, 50/5 then 9/4. The second op is accepted on the edge that ends the first valid cycle.
        @(negedge clk);
        drive(1'b0, 1'b1, 16'd50, 16'd5);
        @(posedge clk);
        #1;
        drive(1'b0, 1'b1, 16'd9, 16'd4);
        wait_valid(1'b0, n);
        check("b2b1_lat", 32'(n), 32'd17);
        check("b2b1_out", 32'(bs.div_out), 32'd10);
        check("b2b1_rem", 32'(bs.div_rem), 32'd0);
        @(posedge clk);
        #1;
        drive(1'b0, 1'b0, 16'd0, 16'd0);
        check("b2b2_accepted", 32'(bs.div_busy), 32'd1);
        wait_valid(1'b0, n);
        check("b2b2_lat", 32'(n), 32'd17);
        check("b2b2_out", 32'(bs.div_out), 32'd2);
        check("b2b2_rem", 32'(bs.div_rem), 32'd1);
        extra = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            if (bs.div_valid_wb) extra++;
        end
        check("b2b_no_double", 32'(extra), 32'd0);

        // Asynchronous reset in the middle of RUN.
        @(negedge clk);
        drive(1'b0, 1'b1, 16'd100, 16'd7);
        @(posedge clk);
        #1;
        drive(1'b0, 1'b0, 16'd0, 16'd0);
        for (int i = 0; i < 8; i++) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_out",   32'(bs.div_out), 32'd0);
        check("arst_rem",   32'(bs.div_rem), 32'd0);
        check("arst_flags", {29'd0, bs.div_valid_wb, bs.div_dbz, bs.div_busy}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        extra = 0;
        for (int i = 0; i < 25; i++) begin
            @(posedge clk);
            #1;
            if (bs.div_valid_wb) extra++;
        end
        check("arst_no_pulse", 32'(extra), 32'd0);
        do_op(1'b0, 16'd100, 16'd7, 16'd14, 16'd2, 1'b0, "post_rst");

        // Unsigned instance.
        do_op(1'b1, 16'hFFFF, 16'h0010, 16'h0FFF, 16'h000F, 1'b0, "uns_big");
        do_op(1'b1, 16'h8000, 16'hFFFF, 16'h0000, 16'h8000, 1'b0, "uns_small_q");
        do_op(1'b1, 16'hFFFE, 16'h0000, 16'hFFFF, 16'hFFFE, 1'b1, "uns_dbz");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
